// File: rtl/id_ex_stage_pkg.sv
// Shared configuration for the decode-to-execute stage: datapath widths,
// operand-select encodings, ALU opcodes and the packed stage payload.
package id_ex_stage_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ALUOP_LEN = 4;

  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  localparam logic [ALUOP_LEN-1:0] ALUOP_ADD = 4'd0;
  localparam logic [ALUOP_LEN-1:0] ALUOP_SUB = 4'd1;
  localparam logic [ALUOP_LEN-1:0] ALUOP_AND = 4'd2;
  localparam logic [ALUOP_LEN-1:0] ALUOP_OR  = 4'd3;

  typedef struct packed {
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [ALUOP_LEN-1:0] op;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs2;
    logic [4:0]           rd;
    logic                 rd_wen;
    logic                 is_w;
  } id_ex_payload_t;

  localparam int unsigned ID_EX_PAYLOAD_W = $bits(id_ex_payload_t);

  function automatic logic [XLEN-1:0] sel_operand(input logic sel,
                                                  input logic [XLEN-1:0] when0,
                                                  input logic [XLEN-1:0] when1);
    logic [XLEN-1:0] res;
    if (sel) begin
      res = when1;
    end else begin
      res = when0;
    end
    return res;
  endfunction

endpackage

// File: rtl/id_ex_stage_skid.sv
// Generic two-entry valid/ready skid buffer with flush; in_ready is a flop
// so there is no combinational path from out_ready back to the producer.
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Encoding is {main_v, skid_v}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_fire_s;
  logic             out_fire_s;

  assign out_valid  = state_r[1];
  assign out_data   = main_r;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = state_r[1] & out_ready;

  // Occupancy FSM, payload registers and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= EMPTY;
      main_r   <= {WIDTH{1'b0}};
      skid_r   <= {WIDTH{1'b0}};
      in_ready <= 1'b1;
    end else if (flush) begin
      state_r  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          in_ready <= 1'b1;
          if (in_fire_s) begin
            main_r  <= in_data;
            state_r <= HALF;
          end else begin
            state_r <= EMPTY;
          end
        end
        HALF: begin
          if (in_fire_s && out_fire_s) begin
            main_r   <= in_data;
            state_r  <= HALF;
            in_ready <= 1'b1;
          end else if (in_fire_s) begin
            // Younger instruction parks in skid; main keeps the older one.
            skid_r   <= in_data;
            state_r  <= FULL;
            in_ready <= 1'b0;
          end else if (out_fire_s) begin
            state_r  <= EMPTY;
            in_ready <= 1'b1;
          end else begin
            state_r  <= HALF;
            in_ready <= 1'b1;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            main_r   <= skid_r;
            state_r  <= HALF;
            in_ready <= 1'b1;
          end else begin
            state_r  <= FULL;
            in_ready <= 1'b0;
          end
        end
        default: begin
          state_r  <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: selects ALU operands at the input and holds them in
// a skid buffer. Optional perf counters are built when ID_EX_PERF_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic [XLEN-1:0]      id_rs1_data_i,
  input  logic [XLEN-1:0]      id_rs2_data_i,
  input  logic [XLEN-1:0]      id_imm_i,
  input  logic [ALUOP_LEN-1:0] id_alu_op_i,
  input  logic                 id_src_a_sel_i,
  input  logic                 id_src_b_sel_i,
  input  logic [4:0]           id_rd_i,
  input  logic                 id_rd_wen_i,
  input  logic                 id_is_w_i,
  input  logic                 flush_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [XLEN-1:0]      alu_a_o,
  output logic [XLEN-1:0]      alu_b_o,
  output logic [ALUOP_LEN-1:0] alu_op_o,
  output logic [XLEN-1:0]      ex_pc_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [4:0]           ex_rd_o,
  output logic                 ex_rd_wen_o,
  output logic                 ex_is_w_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     bubble_cnt_o
`endif
);

  if (CNT_W < 32'd1) begin : g_bad_cnt_w
    $error("id_ex_stage: CNT_W must be at least 1");
  end

  id_ex_payload_t in_pl_s;
  id_ex_payload_t out_pl_s;

  // Operand select and payload packing.
  always_comb begin
    in_pl_s        = '0;
    in_pl_s.a      = sel_operand(id_src_a_sel_i, id_rs1_data_i, id_pc_i);
    in_pl_s.b      = sel_operand(id_src_b_sel_i, id_rs2_data_i, id_imm_i);
    in_pl_s.op     = id_alu_op_i;
    in_pl_s.pc     = id_pc_i;
    in_pl_s.rs2    = id_rs2_data_i;
    in_pl_s.rd     = id_rd_i;
    in_pl_s.rd_wen = id_rd_wen_i;
    in_pl_s.is_w   = id_is_w_i;
  end

  pipe_skid_buf #(
    .WIDTH (ID_EX_PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (id_valid_i),
    .in_ready  (id_ready_o),
    .in_data   (in_pl_s),
    .out_valid (ex_valid_o),
    .out_ready (ex_ready_i),
    .out_data  (out_pl_s)
  );

  assign alu_a_o       = out_pl_s.a;
  assign alu_b_o       = out_pl_s.b;
  assign alu_op_o      = out_pl_s.op;
  assign ex_pc_o       = out_pl_s.pc;
  assign ex_rs2_data_o = out_pl_s.rs2;
  assign ex_rd_o       = out_pl_s.rd;
  assign ex_rd_wen_o   = out_pl_s.rd_wen;
  assign ex_is_w_o     = out_pl_s.is_w;

`ifdef ID_EX_PERF_EN
  // Stall and bubble counters; cleared by reset only, wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o  <= {CNT_W{1'b0}};
      bubble_cnt_o <= {CNT_W{1'b0}};
    end else begin
      if (ex_valid_o && !ex_ready_i) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end else begin
        stall_cnt_o <= stall_cnt_o;
      end
      if (!ex_valid_o) begin
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      end else begin
        bubble_cnt_o <= bubble_cnt_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven directed bench for id_ex_stage plus hand-written reset and
// counter sequences.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct {
    logic sa, sb;
    logic [63:0] rs1, rs2, pc, imm;
    logic [3:0] op;
    logic [4:0] rd;
    logic wen, w;
  } ins_t;

  typedef struct {
    logic [63:0] a, b, pc, rs2;
    logic [3:0] op;
    logic [4:0] rd;
    logic wen, w;
  } exp_t;

  typedef struct {
    string name;
    logic v, fl, er;
    ins_t in;
    logic e_v, e_rdy;
    exp_t ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid_i, id_ready_o, id_src_a_sel_i, id_src_b_sel_i, id_rd_wen_i, id_is_w_i;
  logic [XLEN-1:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [ALUOP_LEN-1:0] id_alu_op_i, alu_op_o;
  logic [4:0] id_rd_i, ex_rd_o;
  logic flush_i, ex_valid_o, ex_ready_i, ex_rd_wen_o, ex_is_w_o;
  logic [XLEN-1:0] alu_a_o, alu_b_o, ex_pc_o, ex_rs2_data_o;
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_o, bubble_cnt_o;
`endif

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_alu_op_i(id_alu_op_i),
    .id_src_a_sel_i(id_src_a_sel_i), .id_src_b_sel_i(id_src_b_sel_i),
    .id_rd_i(id_rd_i), .id_rd_wen_i(id_rd_wen_i), .id_is_w_i(id_is_w_i),
    .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .ex_pc_o(ex_pc_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_o(ex_rd_o), .ex_rd_wen_o(ex_rd_wen_o), .ex_is_w_o(ex_is_w_o)
`ifdef ID_EX_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  // Instruction k: operand selects come from k[0]/k[1], all fields distinct.
  function automatic ins_t ins(input int k);
    ins_t r;
    logic [7:0] kb;
    kb = k[7:0];
    r.sa  = kb[0];
    r.sb  = kb[1];
    r.rs1 = 64'h1000 + 64'(kb);
    r.rs2 = 64'h2000 + 64'(kb);
    r.pc  = 64'h8000 + 64'(kb) * 64'd4;
    r.imm = 64'hFFFF_FFFF_FFFF_FF00 | 64'(kb);
    r.op  = kb[3:0];
    r.rd  = kb[4:0] + 5'd1;
    r.wen = kb[1];
    r.w   = kb[2];
    return r;
  endfunction

  // Expected execute-side view of instruction k.
  function automatic exp_t exp_of(input int k);
    exp_t e;
    logic [7:0] kb;
    kb = k[7:0];
    e.a   = kb[0] ? (64'h8000 + 64'(kb) * 64'd4) : (64'h1000 + 64'(kb));
    e.b   = kb[1] ? (64'hFFFF_FFFF_FFFF_FF00 | 64'(kb)) : (64'h2000 + 64'(kb));
    e.op  = kb[3:0];
    e.pc  = 64'h8000 + 64'(kb) * 64'd4;
    e.rs2 = 64'h2000 + 64'(kb);
    e.rd  = kb[4:0] + 5'd1;
    e.wen = kb[1];
    e.w   = kb[2];
    return e;
  endfunction

  task automatic add(input string nm, input logic v, input logic fl, input logic er,
                     input ins_t in, input logic ev, input logic erdy, input exp_t ex);
    vec_t t;
    t.name = nm; t.v = v; t.fl = fl; t.er = er; t.in = in;
    t.e_v = ev; t.e_rdy = erdy; t.ex = ex;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic v, input logic fl, input logic er, input ins_t in);
    id_valid_i = v; flush_i = fl; ex_ready_i = er;
    id_src_a_sel_i = in.sa; id_src_b_sel_i = in.sb;
    id_rs1_data_i = in.rs1; id_rs2_data_i = in.rs2; id_pc_i = in.pc; id_imm_i = in.imm;
    id_alu_op_i = in.op; id_rd_i = in.rd; id_rd_wen_i = in.wen; id_is_w_i = in.w;
  endtask

  task automatic check(input string nm, input logic ev, input logic erdy,
                       input exp_t ex, input logic chk_pl);
    logic ok;
    n_vec++;
    ok = (ex_valid_o === ev) && (id_ready_o === erdy);
    if (chk_pl) begin
      ok = ok && (alu_a_o === ex.a) && (alu_b_o === ex.b) && (alu_op_o === ex.op) &&
           (ex_pc_o === ex.pc) && (ex_rs2_data_o === ex.rs2) && (ex_rd_o === ex.rd) &&
           (ex_rd_wen_o === ex.wen) && (ex_is_w_o === ex.w);
    end
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got v=%0b rdy=%0b a=%h b=%h op=%h pc=%h rs2=%h rd=%0d wen=%0b w=%0b; want v=%0b rdy=%0b a=%h b=%h op=%h pc=%h rs2=%h rd=%0d wen=%0b w=%0b",
               nm, ex_valid_o, id_ready_o, alu_a_o, alu_b_o, alu_op_o, ex_pc_o, ex_rs2_data_o,
               ex_rd_o, ex_rd_wen_o, ex_is_w_o, ev, erdy, ex.a, ex.b, ex.op, ex.pc, ex.rs2,
               ex.rd, ex.wen, ex.w);
    end
  endtask

  initial begin
    ins_t z, p;
    exp_t zx, e1, ep;
    z  = '{default: '0};
    zx = '{default: '0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, z);
    repeat (3) @(posedge clk);
    #1 check("reset", 1'b0, 1'b1, zx, 1'b1);

    // Single instruction: rs1=5, imm=7, add.
    p = z; p.rs1 = 64'd5; p.imm = 64'd7; p.sb = SRC_B_IMM; p.op = ALUOP_ADD;
    e1 = zx; e1.a = 64'd5; e1.b = 64'd7; e1.op = ALUOP_ADD;
    add("single", 1'b1, 1'b0, 1'b1, p, 1'b1, 1'b1, e1);
    add("single_drain", 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, zx);
    // Back-to-back stream of 10.
    for (int k = 0; k < 10; k++) begin
      add($sformatf("stream%0d", k), 1'b1, 1'b0, 1'b1, ins(k), 1'b1, 1'b1, exp_of(k));
    end
    add("stream_end", 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, zx);
    // Stall with A, B, C.
    add("stall_a", 1'b1, 1'b0, 1'b0, ins(20), 1'b1, 1'b1, exp_of(20));
    add("stall_b", 1'b1, 1'b0, 1'b0, ins(21), 1'b1, 1'b0, exp_of(20));
    add("stall_c_held", 1'b1, 1'b0, 1'b0, ins(22), 1'b1, 1'b0, exp_of(20));
    add("drain_a", 1'b1, 1'b0, 1'b1, ins(22), 1'b1, 1'b1, exp_of(21));
    add("drain_b_take_c", 1'b1, 1'b0, 1'b1, ins(22), 1'b1, 1'b1, exp_of(22));
    add("drain_c", 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, zx);
    // Flush from FULL with input offered.
    add("fl_d", 1'b1, 1'b0, 1'b0, ins(30), 1'b1, 1'b1, exp_of(30));
    add("fl_e", 1'b1, 1'b0, 1'b0, ins(31), 1'b1, 1'b0, exp_of(30));
    add("flush_full", 1'b1, 1'b1, 1'b0, ins(32), 1'b0, 1'b1, zx);
    add("flush_after", 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, zx);
    // Flush from HALF while both handshakes fire.
    add("fl_g", 1'b1, 1'b0, 1'b0, ins(33), 1'b1, 1'b1, exp_of(33));
    add("flush_half", 1'b1, 1'b1, 1'b1, ins(34), 1'b0, 1'b1, zx);
    add("flush_half_after", 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, zx);
    // PC as operand A, then stall into FULL.
    p = z; p.sa = SRC_A_PC; p.sb = SRC_B_RS2; p.pc = 64'h8000_0000; p.rs1 = 64'h123;
    p.rs2 = 64'h55; p.imm = 64'h77; p.op = ALUOP_SUB; p.rd = 5'd3; p.wen = 1'b1;
    ep = zx; ep.a = 64'h8000_0000; ep.b = 64'h55; ep.pc = 64'h8000_0000; ep.rs2 = 64'h55;
    ep.op = ALUOP_SUB; ep.rd = 5'd3; ep.wen = 1'b1;
    add("pc_sel", 1'b1, 1'b0, 1'b0, p, 1'b1, 1'b1, ep);
    add("pc_sel_full", 1'b1, 1'b0, 1'b0, ins(40), 1'b1, 1'b0, ep);

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].fl, tbl[i].er, tbl[i].in);
      @(posedge clk);
      #1 check(tbl[i].name, tbl[i].e_v, tbl[i].e_rdy, tbl[i].ex, tbl[i].e_v);
    end

    // Asynchronous reset in the middle of a stall, sampled before any edge.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, z);
    rst_n = 1'b0;
    #2 check("async_reset", 1'b0, 1'b1, zx, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, ins(50));
    @(posedge clk);
    #1 check("first_after_reset", 1'b1, 1'b1, exp_of(50), 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, z);
    @(posedge clk);
    #1 check("drain_after_reset", 1'b0, 1'b1, zx, 1'b0);

`ifdef ID_EX_PERF_EN
    // One bubble, load, three stalls, consume, one more bubble.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, z);
    #2;
    n_vec++;
    if (stall_cnt_o !== 32'd0 || bubble_cnt_o !== 32'd0) begin
      n_bad++;
      $display("FAIL cnt_reset: stall=%0d bubble=%0d, want 0 0", stall_cnt_o, bubble_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, ins(60));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, z);
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, z);
    @(negedge clk);
    @(posedge clk);
    #1;
    n_vec++;
    if (stall_cnt_o !== 32'd3 || bubble_cnt_o !== 32'd2) begin
      n_bad++;
      $display("FAIL perf_cnt: stall=%0d bubble=%0d, want 3 2", stall_cnt_o, bubble_cnt_o);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
